// File: rtl/clock_divider_prog.sv
// rtl/clock_divider_prog.sv - programmable integer clock divider (ratio 2..2^DIV_W-1, 0 = stop)
// Optional CLKDIV_ODD_DUTY50_EN: negedge trim giving exact 50% duty for odd ratios.
module clock_divider_prog #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_div_valid,
    output logic             o_div_ready,
    output logic             o_clk,
    output logic             o_pulse,
    output logic [DIV_W-1:0] o_div_active
);

    localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'((DEFAULT_DIV == 1) ? 2 : DEFAULT_DIV);

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d == DIV_W'(1)) ? DIV_W'(2) : d;
    endfunction

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] active;
    logic [DIV_W-1:0] pending;
    logic             pending_vld;
    logic             clk_int;
    logic             pulse_q;

    logic [DIV_W-1:0] high_len;
    logic             stopped;
    logic             last;
    logic             accept;
    logic             apply;

    always_comb begin
        high_len = active - (active >> 1);
        stopped  = (active == '0);
        last     = !stopped && (cnt == active - DIV_W'(1));
        accept   = i_div_valid && !pending_vld;
        // A new ratio only lands on a period boundary (or immediately when stopped).
        apply    = pending_vld && (last || stopped);
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            cnt         <= '0;
            active      <= RESET_DIV;
            pending     <= '0;
            pending_vld <= 1'b0;
            clk_int     <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            if (apply) begin
                active      <= clamp_div(pending);
                cnt         <= '0;
                pending_vld <= 1'b0;
            end else if (stopped || last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end

            if (accept) begin
                pending     <= i_div;
                pending_vld <= 1'b1;
            end

            // Outputs follow the pre-edge count, so they trail cnt by one cycle.
            clk_int <= !stopped && (cnt < high_len);
            pulse_q <= !stopped && (cnt == '0);
        end
    end

`ifdef CLKDIV_ODD_DUTY50_EN
    logic neg_copy;

    always_ff @(negedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            neg_copy <= 1'b0;
        end else begin
            neg_copy <= clk_int;
        end
    end

    // Delaying the rising edge by half a source cycle trims the extra high cycle of odd ratios.
    assign o_clk = active[0] ? (clk_int && neg_copy) : clk_int;
`else
    assign o_clk = clk_int;
`endif

    assign o_pulse      = pulse_q;
    assign o_div_ready  = !pending_vld;
    assign o_div_active = active;

endmodule
